// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receiver with a scan-code byte FIFO and a make/break parser.
// Drives an external combinational scan-code-to-ASCII table and reports the held key.
module ps2_kbd_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             pause,
  output logic [7:0]       lut_code,
  input  logic [7:0]       lut_ascii,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic [7:0]       key_ascii,
  output logic [CNT_W-1:0] key_cnt,
  output logic             overflow,
  output logic             err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_BRK  = 2'd2;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  logic [2:0]  r_sync;
  logic [9:0]  r_shift;
  logic [3:0]  r_cnt;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [1:0]  r_state;

  logic       w_fall;
  logic       w_frame_end;
  logic       w_frame_ok;
  logic [7:0] w_rx_byte;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_wr_en;
  logic       w_drop;
  logic [7:0] w_head;

  // ---------------------------------------------------------------------------
  // ps2_clk synchroniser and falling-edge detect on the two oldest stages
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the shift chain work.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_sync <= '0;
    else       r_sync <= {r_sync[1:0], ps2_clk};
  end

  assign w_fall = r_sync[2] & ~r_sync[1];

  // ---------------------------------------------------------------------------
  // Frame receiver: start, 8 data LSB first, parity, then stop checked live
  // ---------------------------------------------------------------------------
  assign w_frame_end = w_fall && (r_cnt == 4'd10);
  assign w_rx_byte   = r_shift[8:1];
  assign w_frame_ok  = w_frame_end && !r_shift[0] && ps2_data && (^r_shift[9:1]);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_shift <= '0;
      r_cnt   <= '0;
      err     <= 1'b0;
    end else begin
      err <= w_frame_end && !w_frame_ok;
      if (w_fall) begin
        if (r_cnt == 4'd10) begin
          r_cnt <= '0;
        end else begin
          r_shift <= {ps2_data, r_shift[9:1]};
          r_cnt   <= r_cnt + 4'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Byte FIFO; the extra pointer bit separates full from empty
  // ---------------------------------------------------------------------------
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && !pause;
  assign w_wr_en = w_frame_ok && (!w_full || w_pop);
  assign w_drop  = w_frame_ok && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign lut_code = w_empty ? 8'h00 : w_head;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      if (w_drop)  overflow <= 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers define which entries are valid,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_rx_byte;
  end

  // ---------------------------------------------------------------------------
  // Make/break parser, advancing once per popped byte
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state   <= ST_IDLE;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_ascii <= '0;
      key_cnt   <= '0;
    end else if (w_pop) begin
      case (r_state)
        ST_IDLE: begin
          if (w_head == CODE_BRK) begin
            r_state <= ST_BRK;
          end else if (w_head != CODE_EXT) begin
            key_code  <= w_head;
            key_ascii <= lut_ascii;
            key_valid <= 1'b1;
            key_cnt   <= key_cnt + CNT_W'(1);
            r_state   <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (w_head == CODE_BRK) begin
            r_state <= ST_BRK;
          end else if (w_head != CODE_EXT && w_head != key_code) begin
            key_code  <= w_head;
            key_ascii <= lut_ascii;
            key_cnt   <= key_cnt + CNT_W'(1);
          end
        end
        ST_BRK: begin
          // Release ends on the first non-prefix byte, whichever key it names.
          if (w_head != CODE_EXT) begin
            key_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
